// File: rtl/mem_wb_pkg.sv
// Shared defaults and payload layout for the MEM/WB pipeline stage.
// The MEM_WB_SKID_EN macro (see pipe_skid_reg) selects the two-entry variant.
package mem_wb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RA_W_DEF  = 5;
  localparam int CNT_W_DEF = 16;

  // Architectural zero register: writes to it never reach the register file.
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [RA_W_DEF-1:0] rd;
    logic                memtoreg;
    logic                regwrite;
    logic [XLEN_DEF-1:0] alu_out;
    logic [XLEN_DEF-1:0] mem_rdata;
  } mem_wb_payload_t;

  localparam int PAYLOAD_W_DEF = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready payload register with flush. Define MEM_WB_SKID_EN for a
// second (skid) entry that removes the out_ready -> in_ready combinational path.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // a held beat keeps its payload stable until it is consumed or flushed.
  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

`ifdef MEM_WB_SKID_EN
  logic         skid_valid;
  logic [W-1:0] skid_data;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid) begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end
    end else if (out_xfer) begin
      // Skid full implies in_ready low, so no new beat can arrive here.
      if (skid_valid) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = out_ready | !out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: handshaked payload register plus register-file write
// decode and a saturating bubble counter. MEM_WB_SKID_EN adds a skid entry.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_memtoreg,
  input  logic             in_regwrite,
  input  logic [XLEN-1:0]  in_alu_out,
  input  logic [XLEN-1:0]  in_mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_memtoreg,
  output logic             out_regwrite,
  output logic [XLEN-1:0]  out_alu_out,
  output logic [XLEN-1:0]  out_mem_rdata,
  output logic             wb_we,
  output logic [RA_W-1:0]  wb_waddr,
  output logic [XLEN-1:0]  wb_wdata,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            memtoreg;
    logic            regwrite;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mem_rdata;
  } payload_t;

  localparam int PW = $bits(payload_t);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  payload_t in_pl;
  payload_t out_pl;

  assign in_pl.rd        = in_rd;
  assign in_pl.memtoreg  = in_memtoreg;
  assign in_pl.regwrite  = in_regwrite;
  assign in_pl.alu_out   = in_alu_out;
  assign in_pl.mem_rdata = in_mem_rdata;

  pipe_skid_reg #(
    .W (PW)
  ) u_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign out_rd        = out_pl.rd;
  assign out_memtoreg  = out_pl.memtoreg;
  assign out_regwrite  = out_pl.regwrite;
  assign out_alu_out   = out_pl.alu_out;
  assign out_mem_rdata = out_pl.mem_rdata;

  // Register-file write port; these also feed the forwarding unit.
  assign wb_we    = out_valid & out_regwrite & (out_rd != RA_W'(REG_ZERO));
  assign wb_waddr = out_rd;
  assign wb_wdata = out_memtoreg ? out_mem_rdata : out_alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: a queue-based occupancy model predicts
// in_ready, out_valid, payload order, WB decode and the bubble counter.
module tb_mem_wb_pipe;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int PW   = RA_W + 2 + 2 * XLEN;
  localparam logic [15:0] BUB_MAX = 16'hFFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            flush_i = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [RA_W-1:0] in_rd = '0;
  logic            in_memtoreg = 1'b0;
  logic            in_regwrite = 1'b0;
  logic [XLEN-1:0] in_alu_out = '0;
  logic [XLEN-1:0] in_mem_rdata = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [RA_W-1:0] out_rd;
  logic            out_memtoreg;
  logic            out_regwrite;
  logic [XLEN-1:0] out_alu_out;
  logic [XLEN-1:0] out_mem_rdata;
  logic            wb_we;
  logic [RA_W-1:0] wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic [15:0]     bubble_cnt;

  mem_wb_pipe dut (
    .clk (clk), .rst_n (rst_n), .flush_i (flush_i),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_rd (in_rd), .in_memtoreg (in_memtoreg), .in_regwrite (in_regwrite),
    .in_alu_out (in_alu_out), .in_mem_rdata (in_mem_rdata),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_rd (out_rd), .out_memtoreg (out_memtoreg), .out_regwrite (out_regwrite),
    .out_alu_out (out_alu_out), .out_mem_rdata (out_mem_rdata),
    .wb_we (wb_we), .wb_waddr (wb_waddr), .wb_wdata (wb_wdata),
    .bubble_cnt (bubble_cnt)
  );

  // Narrow-counter instance, left idle, for the saturation check.
  logic            sat_in_ready, sat_out_valid, sat_out_memtoreg, sat_out_regwrite, sat_wb_we;
  logic [RA_W-1:0] sat_out_rd, sat_wb_waddr;
  logic [XLEN-1:0] sat_out_alu_out, sat_out_mem_rdata, sat_wb_wdata;
  logic [3:0]      sat_bubble_cnt;

  mem_wb_pipe #(.CNT_W (4)) u_sat (
    .clk (clk), .rst_n (rst_n), .flush_i (1'b0),
    .in_valid (1'b0), .in_ready (sat_in_ready),
    .in_rd ('0), .in_memtoreg (1'b0), .in_regwrite (1'b0),
    .in_alu_out ('0), .in_mem_rdata ('0),
    .out_valid (sat_out_valid), .out_ready (1'b1),
    .out_rd (sat_out_rd), .out_memtoreg (sat_out_memtoreg), .out_regwrite (sat_out_regwrite),
    .out_alu_out (sat_out_alu_out), .out_mem_rdata (sat_out_mem_rdata),
    .wb_we (sat_wb_we), .wb_waddr (sat_wb_waddr), .wb_wdata (sat_wb_wdata),
    .bubble_cnt (sat_bubble_cnt)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [PW-1:0] exp_q[$];
  logic [15:0]   exp_bub = '0;
  int            dut_xfers = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Capacity of the stage as seen from the producer.
  function automatic bit exp_in_ready();
`ifdef MEM_WB_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  // Model update: one step per edge, using the pre-edge inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_bub = '0;
    end else begin
      bit acc;
      acc = in_valid && exp_in_ready();
      if (out_valid && out_ready) dut_xfers++;
      if (exp_q.size() == 0 && exp_bub != BUB_MAX) exp_bub++;
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({in_rd, in_memtoreg, in_regwrite, in_alu_out, in_mem_rdata});
      end
    end
  end

  // Monitor: compare everything the DUT presents against the model.
  always @(negedge clk) begin
    check("in_ready", in_ready, exp_in_ready());
    check("out_valid", out_valid, exp_q.size() != 0);
    check("bubble_cnt", bubble_cnt, exp_bub);
    if (exp_q.size() != 0) begin
      logic [PW-1:0]   e;
      logic [RA_W-1:0] e_rd;
      logic            e_m2r, e_rw;
      logic [XLEN-1:0] e_alu, e_mem;
      e = exp_q[0];
      {e_rd, e_m2r, e_rw, e_alu, e_mem} = e;
      check("out_rd", out_rd, e_rd);
      check("out_memtoreg", out_memtoreg, e_m2r);
      check("out_regwrite", out_regwrite, e_rw);
      check("out_alu_out", out_alu_out, e_alu);
      check("out_mem_rdata", out_mem_rdata, e_mem);
      check("wb_we", wb_we, e_rw && (e_rd != 0));
      check("wb_waddr", wb_waddr, e_rd);
      check("wb_wdata", wb_wdata, e_m2r ? e_mem : e_alu);
    end else begin
      check("wb_we_idle", wb_we, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RA_W-1:0] rd, input logic m2r,
                       input logic rw, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem);
    in_valid     = v;
    in_rd        = rd;
    in_memtoreg  = m2r;
    in_regwrite  = rw;
    in_alu_out   = alu;
    in_mem_rdata = mem;
  endtask

  // Holds the beat until accepted, bounded by max_cycles.
  task automatic send(input logic [RA_W-1:0] rd, input logic m2r, input logic rw,
                      input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem, input int max_cycles);
    bit acc;
    acc = 1'b0;
    drive(1'b1, rd, m2r, rw, alu, mem);
    for (int i = 0; i < max_cycles && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic random_beat(input logic v);
    logic [RA_W-1:0] rd;
    rd = ($urandom_range(0, 7) == 0) ? '0 : RA_W'($urandom_range(0, 31));
    drive(v, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] b0;
    int          x0;
    bit          b_acc;

    repeat (3) step();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_rd", out_rd, '0);
    check("reset_out_alu", out_alu_out, '0);
    check("reset_out_mem", out_mem_rdata, '0);
    check("reset_bubble", bubble_cnt, '0);
    rst_n = 1'b1;

    // Idle long enough for the narrow counter to saturate.
    repeat (20) step();
    check("sat_bubble_15", sat_bubble_cnt, 4'd15);

    // Plain ALU writeback.
    out_ready = 1'b1;
    send(5'd5, 1'b0, 1'b1, 32'h1234, 32'h0, 2);
    check("dir1_wb_we", wb_we, 1'b1);
    check("dir1_wb_waddr", wb_waddr, 5'd5);
    check("dir1_wb_wdata", wb_wdata, 32'h1234);

    // Load to x0: visible but write suppressed.
    send(5'd0, 1'b1, 1'b1, 32'h55, 32'hDEADBEEF, 2);
    check("dir2_out_valid", out_valid, 1'b1);
    check("dir2_wb_we", wb_we, 1'b0);
    check("dir2_wb_wdata", wb_wdata, 32'hDEADBEEF);
    step();

    // Stall: A accepted, B offered for three cycles.
    out_ready = 1'b0;
    send(5'd1, 1'b0, 1'b1, 32'hA, 32'h0, 2);
    drive(1'b1, 5'd2, 1'b0, 1'b1, 32'hB, 32'h0);
    b_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready && in_valid) b_acc = 1'b1;
      step();
      if (b_acc) in_valid = 1'b0;
    end
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_alu", out_alu_out, 32'hA);
    out_ready = 1'b1;
    if (!b_acc) send(5'd2, 1'b0, 1'b1, 32'hB, 32'h0, 4);
    repeat (3) step();

    // Flush with both entries occupied and a beat arriving.
    out_ready = 1'b0;
    send(5'd3, 1'b0, 1'b1, 32'hC, 32'h0, 2);
    drive(1'b1, 5'd4, 1'b0, 1'b1, 32'hD, 32'h0);
    step();
    drive(1'b1, 5'd6, 1'b0, 1'b1, 32'hE, 32'h0);
    flush_i = 1'b1;
    step();
    flush_i  = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_wb_we", wb_we, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();

    // Back-to-back burst of 100 beats.
    x0 = dut_xfers;
    random_beat(1'b1);
    step();
    b0 = exp_bub;
    for (int i = 1; i < 100; i++) begin
      random_beat(1'b1);
      step();
    end
    in_valid = 1'b0;
    check("burst_bubble_const", bubble_cnt, b0);
    step();
    check("burst_xfers", dut_xfers - x0, 100);

    // Reset asserted mid-burst.
    for (int i = 0; i < 10; i++) begin
      random_beat(1'b1);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_bubble", bubble_cnt, '0);
    check("rst_mid_out_alu", out_alu_out, '0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      random_beat(1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush_i   = ($urandom_range(0, 31) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush_i   = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", out_valid, 1'b0);
    check("sat_bubble_end", sat_bubble_cnt, 4'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
